// File: rtl/ex_ret_fifo.sv
// ex_ret_fifo: buffer between the execute stage and retire.
// Completed ops are queued in order and the head entry is presented
// combinationally to retire. A retire flush empties the queue.
//
// Optional build macro: QU_EX_RET_FIFO_BYPASS_EN
//   When defined, a push into an empty queue that retire accepts in the
//   same cycle goes straight to the outputs and is not stored.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   push_en           execute presents a completed op
//   push_value        execute result
//   push_comp_result  branch comparison outcome
//   push_op           reservation-station cell (valid when op.optype[0])
//   pop_ready         retire accepts the head entry
//   flush             mispredict flush from retire
//   value_out         head result
//   comp_result_out   head comparison result
//   op_out            head cell, all-zero bubble when empty
//   full, empty       occupancy flags
//   count             occupied entries
//   overflow_err      sticky dropped-push flag

package ex_ret_fifo_pkg;

  typedef logic [31:0] phy_rf_data_t;

  typedef struct packed {
    logic [3:0] optype;
    logic [5:0] dst;
    logic [5:0] src_a;
    logic [5:0] src_b;
  } uop_t;

  typedef struct packed {
    uop_t       op;
    logic [3:0] rob_tag;
  } res_st_cell_t;

endpackage

module ex_ret_fifo
  import ex_ret_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push_en,
  input  logic [$bits(phy_rf_data_t)-1:0]   push_value,
  input  logic                              push_comp_result,
  input  logic [$bits(res_st_cell_t)-1:0]   push_op,
  input  logic                              pop_ready,
  input  logic                              flush,
  output logic [$bits(phy_rf_data_t)-1:0]   value_out,
  output logic                              comp_result_out,
  output logic [$bits(res_st_cell_t)-1:0]   op_out,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              overflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned VAL_W = $bits(phy_rf_data_t);
  localparam int unsigned OP_W  = $bits(res_st_cell_t);

  res_st_cell_t            push_cell;
  logic                    push_valid;
  logic                    push_acc;
  logic                    pop;
  logic                    bypass;
  logic                    wr_en;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;

  phy_rf_data_t            val_mem  [DEPTH];
  logic                    comp_mem [DEPTH];
  res_st_cell_t            op_mem   [DEPTH];

  // Decode of the incoming cell and handshake qualifiers
  assign push_cell  = res_st_cell_t'(push_op);
  assign push_valid = push_en & push_cell.op.optype[0];
  assign push_acc   = push_valid & ~full & ~flush;
  assign pop        = ~empty & pop_ready & ~flush;

`ifdef QU_EX_RET_FIFO_BYPASS_EN
  // Empty queue and retire ready: forward push data without storing it
  assign bypass = empty & push_acc & pop_ready & ~rst;
`else
  assign bypass = 1'b0;
`endif

  assign wr_en = push_acc & ~bypass;

  // Flags depend only on the registered count
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Pointer, occupancy and error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(pop);
      // A valid op arriving while full is lost, even if a pop frees a slot
      if (push_valid && full) overflow_err <= 1'b1;
    end
  end

  // Entry storage, no reset needed since contents behind rd_ptr are unused
  always_ff @(posedge clk) begin
    if (wr_en) begin
      val_mem[wr_ptr]  <= push_value;
      comp_mem[wr_ptr] <= push_comp_result;
      op_mem[wr_ptr]   <= push_cell;
    end
  end

  // Head presentation: bypass data, stored head, or zero bubble
  always_comb begin
    value_out       = '0;
    comp_result_out = 1'b0;
    op_out          = '0;
    if (bypass) begin
      value_out       = push_value;
      comp_result_out = push_comp_result;
      op_out          = push_op;
    end else if (!empty) begin
      value_out       = VAL_W'(val_mem[rd_ptr]);
      comp_result_out = comp_mem[rd_ptr];
      op_out          = OP_W'(op_mem[rd_ptr]);
    end
  end

endmodule

// File: tb/tb_ex_ret_fifo.sv
// Directed self-checking bench for ex_ret_fifo (DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are sampled at the
// falling edge unless a same-cycle asynchronous effect is being checked.
module tb_ex_ret_fifo;
  import ex_ret_fifo_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned VAL_W = $bits(phy_rf_data_t);
  localparam int unsigned OP_W  = $bits(res_st_cell_t);

  logic              clk = 1'b0;
  logic              rst;
  logic              push_en;
  logic [VAL_W-1:0]  push_value;
  logic              push_comp_result;
  logic [OP_W-1:0]   push_op;
  logic              pop_ready;
  logic              flush;
  logic [VAL_W-1:0]  value_out;
  logic              comp_result_out;
  logic [OP_W-1:0]   op_out;
  logic              full;
  logic              empty;
  logic [2:0]        count;
  logic              overflow_err;

  int n_chk  = 0;
  int n_pass = 0;

  ex_ret_fifo #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .push_en          (push_en),
    .push_value       (push_value),
    .push_comp_result (push_comp_result),
    .push_op          (push_op),
    .pop_ready        (pop_ready),
    .flush            (flush),
    .value_out        (value_out),
    .comp_result_out  (comp_result_out),
    .op_out           (op_out),
    .full             (full),
    .empty            (empty),
    .count            (count),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [OP_W-1:0] mk_op(input logic [3:0] optype, input logic [3:0] tag);
    res_st_cell_t c;
    c.op.optype = optype;
    c.op.dst    = 6'(tag) + 6'd8;
    c.op.src_a  = 6'(tag) + 6'd1;
    c.op.src_b  = 6'(tag) + 6'd2;
    c.rob_tag   = tag;
    return OP_W'(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_push(input logic [VAL_W-1:0] v, input logic [3:0] optype, input logic [3:0] tag);
    push_en          = 1'b1;
    push_value       = v;
    push_comp_result = v[0];
    push_op          = mk_op(optype, tag);
  endtask

  task automatic idle_push();
    push_en          = 1'b0;
    push_value       = '0;
    push_comp_result = 1'b0;
    push_op          = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; pop_ready = 1'b0;
    idle_push();

    // Reset state
    #3;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_op", 64'(op_out), 64'd0);
    check("rst_ovf", 64'(overflow_err), 64'd0);
    tick(); tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      mid();
      check("idle", {61'd0, empty, full, |op_out}, 64'b100);
      check("idle_cnt", 64'(count), 64'd0);
      tick();
    end

    // Fill to full, overflow, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive_push(VAL_W'(32'h10 + i), 4'h1, 4'(i));
      tick();
    end
    drive_push(32'h99, 4'h1, 4'hF);
    mid();
    check("full_flag", 64'(full), 64'd1);
    check("full_cnt", 64'(count), 64'd4);
    tick();
    idle_push();
    mid();
    check("ovf_set", 64'(overflow_err), 64'd1);
    check("ovf_cnt", 64'(count), 64'd4);
    tick();
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("drain_val", 64'(value_out), 64'(32'h10 + i));
      check("drain_op", 64'(op_out), 64'(mk_op(4'h1, 4'(i))));
      check("drain_cmp", 64'(comp_result_out), 64'(i % 2));
      tick();
    end
    mid();
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_val0", 64'(value_out), 64'd0);
    check("ovf_sticky", 64'(overflow_err), 64'd1);
    tick();

    // Asynchronous reset mid-burst
    pop_ready = 1'b0;
    drive_push(32'h40, 4'h1, 4'h4); tick();
    drive_push(32'h41, 4'h1, 4'h5); tick();
    idle_push();
    mid();
    check("pre_rst_val", 64'(value_out), 64'h40);
    #2 rst = 1'b1;
    #1;
    check("arst_cnt", 64'(count), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_val", 64'(value_out), 64'd0);
    check("arst_op", 64'(op_out), 64'd0);
    check("arst_ovf", 64'(overflow_err), 64'd0);
    tick(); tick();
    rst = 1'b0;

    // Flush with three entries held and a same-cycle push
    for (int i = 0; i < 3; i++) begin
      drive_push(VAL_W'(32'h20 + i), 4'h1, 4'(i));
      tick();
    end
    mid();
    check("pre_flush_cnt", 64'(count), 64'd3);
    tick();
    flush = 1'b1;
    drive_push(32'h77, 4'h1, 4'h7);
    tick();
    flush = 1'b0;
    idle_push();
    pop_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      check("flush_cnt", 64'(count), 64'd0);
      check("flush_empty", 64'(empty), 64'd1);
      check("flush_op", 64'(op_out), 64'd0);
      check("flush_val", 64'(value_out), 64'd0);
      tick();
    end

    // Invalid op (optype[0]=0) is ignored
    pop_ready = 1'b0;
    drive_push(32'h30, 4'h1, 4'h3); tick();
    drive_push(32'h31, 4'h2, 4'h6); tick();
    idle_push();
    mid();
    check("inv_cnt", 64'(count), 64'd1);
    check("inv_val", 64'(value_out), 64'h30);
    tick();
    pop_ready = 1'b1;
    tick();
    mid();
    check("inv_drain", 64'(empty), 64'd1);
    tick();

    // Continuous push and pop through three wraps
    for (int i = 0; i < 12; i++) begin
      drive_push(VAL_W'(i), 4'h1, 4'(i));
      mid();
`ifdef QU_EX_RET_FIFO_BYPASS_EN
      check("stream_val", 64'(value_out), 64'(i));
      check("stream_cnt", 64'(count), 64'd0);
`else
      check("stream_val", 64'(value_out), 64'((i == 0) ? 0 : i - 1));
      check("stream_cnt", 64'(count), 64'((i == 0) ? 0 : 1));
`endif
      tick();
    end
    idle_push();
    mid();
`ifndef QU_EX_RET_FIFO_BYPASS_EN
    check("stream_last", 64'(value_out), 64'd11);
    tick();
    mid();
`endif
    check("stream_empty", 64'(empty), 64'd1);
    check("stream_ovf", 64'(overflow_err), 64'd0);
    tick();

    // Push into empty queue with retire ready
    drive_push(32'hABCD, 4'h1, 4'h9);
    mid();
`ifdef QU_EX_RET_FIFO_BYPASS_EN
    check("byp_val", 64'(value_out), 64'hABCD);
    check("byp_cnt", 64'(count), 64'd0);
`else
    check("nobyp_val", 64'(value_out), 64'd0);
    check("nobyp_empty", 64'(empty), 64'd1);
`endif
    tick();
    idle_push();
    mid();
`ifdef QU_EX_RET_FIFO_BYPASS_EN
    check("byp_after", 64'(empty), 64'd1);
`else
    check("nobyp_val1", 64'(value_out), 64'hABCD);
    check("nobyp_cnt1", 64'(count), 64'd1);
    tick();
    mid();
    check("nobyp_drain", 64'(empty), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
